wb_burst_reader: RTL and testbench

- Wishbone classic master that sits directly upstream of the BlockRAM slave on the memory-controller bus.
- On a start pulse it reads a contiguous block of 32-bit words from the slave and buffers them in an internal FIFO.
- It presents the words on a valid/ready stream consumed by the video/pixel pipeline.
- It hides the slave's read latency and applies back-pressure by withholding STB whenever the FIFO is full.

---
 rtl/wb_burst_reader.sv | 137 +++++++++++++
 tb/tb_wb_burst_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_reader.sv
// Wishbone classic read master: fetches NB_WORDS consecutive 32-bit words from
// BASE_ADR and streams them out through a small FIFO with valid/ready handshake.
module wb_burst_reader #(
    parameter logic [31:0] BASE_ADR   = 32'h0000_0000,
    parameter int unsigned NB_WORDS   = 2048,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [3:0]  sel,
    output logic [31:0] adr,
    output logic [31:0] dat_ms,
    input  logic [31:0] dat_sm,
    input  logic        ack,
    input  logic        err,
    input  logic        rty,
    input  logic        start,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int IDX_W = 21;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_WORDS - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       state;
    logic [IDX_W-1:0] idx;
    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic req;
    logic push;
    logic pop;
    logic abort;
    logic last;
    logic unused_rty;

    // Strobe only while there is room, so a granted ack always has a free slot.
    assign req    = (state == S_READ) && (count < DEPTH_C);
    assign cyc    = req;
    assign stb    = req;
    assign we     = 1'b0;
    assign sel    = 4'hF;
    assign dat_ms = '0;
    assign adr    = BASE_ADR + 32'({idx, 2'b00});

    // err wins over a simultaneous ack: the word is dropped and the burst aborted.
    assign abort  = req && err;
    assign push   = req && ack && !err;
    assign last   = push && (idx == LAST_IDX);
    assign pop    = out_valid && out_ready;

    assign out_valid  = (count != '0);
    assign out_data   = fifo_mem[rd_ptr];
    assign busy       = (state != S_IDLE);
    assign unused_rty = rty;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every always_ff reads the pre-edge values regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            done  <= 1'b0;
            error <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_READ;
                        idx   <= '0;
                    end
                end
                S_READ: begin
                    if (abort) begin
                        state <= S_IDLE;
                        error <= 1'b1;
                    end else if (push) begin
                        if (last) begin
                            state <= S_DRAIN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (count == '0) begin
                        state <= S_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; out_valid comes from count, so stale
    // entries are never presented and the array can map onto plain registers/RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= dat_sm;
    end

endmodule

// File: tb/tb_wb_burst_reader.sv
// Self-checking bench for wb_burst_reader: two instances (16-word burst at 0,
// single word at 0x1FFC) each driven by a behavioural BlockRAM slave.
module tb_wb_burst_reader;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] data;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    logic out_ready;
    logic use_b;
    logic comb_mode;
    logic slv_clr;
    int   err_at;

    logic start_a;
    logic start_b;
    assign start_a = start && !use_b;
    assign start_b = start && use_b;

    logic [31:0] mem [0:4095];

    // instance A: 16 words from address 0
    logic        a_cyc, a_stb, a_we, a_ack, a_err, a_ack_q, a_ack_raw;
    logic [3:0]  a_sel;
    logic [31:0] a_adr, a_dat_ms, a_dat_sm, a_dat_q, a_out_data;
    logic        a_out_valid, a_busy, a_done, a_error;
    int          a_xfer;

    // instance B: single word at 0x1FFC
    logic        b_cyc, b_stb, b_we, b_ack, b_ack_q;
    logic [3:0]  b_sel;
    logic [31:0] b_adr, b_dat_ms, b_dat_sm, b_dat_q, b_out_data;
    logic        b_out_valid, b_busy, b_done, b_error;

    wb_burst_reader #(.BASE_ADR(32'h0000_0000), .NB_WORDS(16), .FIFO_DEPTH(8)) dut_a (
        .clk(clk), .rst(rst), .cyc(a_cyc), .stb(a_stb), .we(a_we), .sel(a_sel),
        .adr(a_adr), .dat_ms(a_dat_ms), .dat_sm(a_dat_sm), .ack(a_ack), .err(a_err),
        .rty(1'b0), .start(start_a), .out_data(a_out_data), .out_valid(a_out_valid),
        .out_ready(out_ready), .busy(a_busy), .done(a_done), .error(a_error)
    );

    wb_burst_reader #(.BASE_ADR(32'h0000_1FFC), .NB_WORDS(1), .FIFO_DEPTH(8)) dut_b (
        .clk(clk), .rst(rst), .cyc(b_cyc), .stb(b_stb), .we(b_we), .sel(b_sel),
        .adr(b_adr), .dat_ms(b_dat_ms), .dat_sm(b_dat_sm), .ack(b_ack), .err(1'b0),
        .rty(1'b0), .start(start_b), .out_data(b_out_data), .out_valid(b_out_valid),
        .out_ready(out_ready), .busy(b_busy), .done(b_done), .error(b_error)
    );

    // BlockRAM slaves: registered ack (2 cycles/word) or combinational ack
    always @(posedge clk) begin
        if (rst || slv_clr) begin
            a_ack_q <= 1'b0;
            a_xfer  <= 0;
        end else begin
            a_ack_q <= a_cyc && a_stb && !a_ack_q && !comb_mode;
            if (a_cyc && a_stb && a_ack) a_xfer <= a_xfer + 1;
        end
        a_dat_q <= mem[a_adr[13:2]];
    end
    assign a_ack_raw = comb_mode ? (a_cyc && a_stb) : a_ack_q;
    assign a_ack     = a_ack_raw;
    assign a_err     = a_ack_raw && (a_xfer == err_at);
    assign a_dat_sm  = comb_mode ? mem[a_adr[13:2]] : a_dat_q;

    always @(posedge clk) begin
        if (rst || slv_clr) b_ack_q <= 1'b0;
        else                b_ack_q <= b_cyc && b_stb && !b_ack_q;
        b_dat_q <= mem[b_adr[13:2]];
    end
    assign b_ack    = b_ack_q;
    assign b_dat_sm = b_dat_q;

    // signals of the instance under test
    logic        m_cyc, m_stb, m_ack, m_err, m_valid, m_busy, m_done, m_error;
    logic [31:0] m_adr, m_data;
    assign m_cyc   = use_b ? b_cyc       : a_cyc;
    assign m_stb   = use_b ? b_stb       : a_stb;
    assign m_ack   = use_b ? b_ack       : a_ack;
    assign m_err   = use_b ? 1'b0        : a_err;
    assign m_adr   = use_b ? b_adr       : a_adr;
    assign m_data  = use_b ? b_out_data  : a_out_data;
    assign m_valid = use_b ? b_out_valid : a_out_valid;
    assign m_busy  = use_b ? b_busy      : a_busy;
    assign m_done  = use_b ? b_done      : a_done;
    assign m_error = use_b ? b_error     : a_error;

    vec_t tbl [17];
    int   tbl_off, nb_exp;
    int   n_checks, n_fail;
    int   ready_mode, cyc_cnt;
    logic start_req, rst_req, busy_chk;
    int   n_acks, n_pops, n_done, n_error, n_bus_err;
    int   occ, max_occ, hold_bad, busy_gap, done_bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        n_acks = 0; n_pops = 0; n_done = 0; n_error = 0; n_bus_err = 0;
        occ = 0; max_occ = 0; cyc_cnt = 0; hold_bad = 0; busy_gap = 0;
        done_bad = 0; busy_chk = 1'b0;
    endtask

    task automatic slave_clear();
        @(negedge clk);
        slv_clr = 1'b1;
        @(negedge clk);
        slv_clr = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, then observe and score.
    task automatic mon_cycle();
        @(negedge clk);
        start     = start_req;
        start_req = 1'b0;
        rst       = rst_req;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc_cnt >= 40);
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        cyc_cnt++;
        #1;
        if (m_cyc && m_stb && m_err) begin
            n_bus_err++;
        end else if (m_cyc && m_stb && m_ack) begin
            if (n_acks < nb_exp) check("adr", m_adr, tbl[tbl_off + n_acks].adr);
            else                 check("extra_ack", 32'(n_acks), 32'(nb_exp - 1));
            n_acks++;
            occ++;
        end
        if (m_valid && out_ready) begin
            if (n_pops < nb_exp) check("data", m_data, tbl[tbl_off + n_pops].data);
            else                 check("extra_pop", 32'(n_pops), 32'(nb_exp - 1));
            n_pops++;
            occ--;
        end
        if (occ > max_occ) max_occ = occ;
        if (ready_mode == 1 && !out_ready && m_valid && m_data != tbl[tbl_off].data) hold_bad++;
        if (m_done) begin
            n_done++;
            if (m_valid) done_bad++;
        end
        if (m_error) n_error++;
        if (busy_chk) begin
            if (m_done || m_error) busy_chk = 1'b0;
            else if (!m_busy)      busy_gap++;
        end
        if (rst)        busy_chk = 1'b0;
        else if (start) busy_chk = 1'b1;
    endtask

    task automatic run_burst(input int budget, input int tail);
        int k;
        k = 0;
        while (n_done == 0 && n_error == 0 && k < budget) begin
            mon_cycle();
            k++;
        end
        check("burst_finished", 32'(k < budget), 32'd1);
        repeat (tail) mon_cycle();
    endtask

    initial begin
        int k;
        for (int i = 0; i < 16; i++) begin
            tbl[i].adr  = 32'(i * 4);
            tbl[i].data = 32'(i);
        end
        tbl[16].adr  = 32'h0000_1FFC;
        tbl[16].data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4096; i++) mem[i] = 32'(i);
        mem[2047] = 32'hDEAD_BEEF;

        n_checks = 0; n_fail = 0;
        rst = 1'b1; rst_req = 1'b0; start = 1'b0; start_req = 1'b0;
        out_ready = 1'b0; use_b = 1'b0; comb_mode = 1'b0; slv_clr = 1'b0;
        err_at = 1000; ready_mode = 0; tbl_off = 0; nb_exp = 16;
        clear_stats();
        repeat (3) @(negedge clk);
        #1;

        // reset state of both instances
        check("rst_a_cyc", 32'(a_cyc), 0);
        check("rst_a_stb", 32'(a_stb), 0);
        check("rst_a_valid", 32'(a_out_valid), 0);
        check("rst_a_busy", 32'(a_busy), 0);
        check("rst_a_done_err", {30'd0, a_done, a_error}, 0);
        check("rst_a_adr", a_adr, 32'h0000_0000);
        check("rst_a_ties", {a_we, a_sel, 27'd0}, {1'b0, 4'hF, 27'd0});
        check("rst_a_dat_ms", a_dat_ms, 0);
        check("rst_b_adr", b_adr, 32'h0000_1FFC);
        check("rst_b_outs", {26'd0, b_cyc, b_stb, b_out_valid, b_busy, b_done, b_error}, 0);
        check("rst_b_ties", {b_we, b_sel, 27'd0}, {1'b0, 4'hF, 27'd0});
        check("rst_b_dat_ms", b_dat_ms, 0);
        rst = 1'b0;

        // 1: full burst, consumer always ready
        clear_stats();
        start_req = 1'b1;
        run_burst(200, 6);
        check("t1_acks", 32'(n_acks), 16);
        check("t1_pops", 32'(n_pops), 16);
        check("t1_done_count", 32'(n_done), 1);
        check("t1_busy_gaps", 32'(busy_gap), 0);
        check("t1_done_while_valid", 32'(done_bad), 0);

        // 2: consumer stalls for 40 cycles
        clear_stats();
        ready_mode = 1;
        start_req = 1'b1;
        repeat (40) mon_cycle();
        check("t2_acks_while_stalled", 32'(n_acks), 8);
        check("t2_stb_when_full", 32'(m_stb), 0);
        check("t2_head_held", 32'(hold_bad), 0);
        run_burst(200, 4);
        check("t2_pops", 32'(n_pops), 16);
        check("t2_done_count", 32'(n_done), 1);
        check("t2_max_occ", 32'(max_occ), 8);
        ready_mode = 0;

        // 3: single word at the top of a 2K-word window
        use_b = 1'b1; tbl_off = 16; nb_exp = 1;
        clear_stats();
        start_req = 1'b1;
        run_burst(50, 4);
        check("t3_acks", 32'(n_acks), 1);
        check("t3_pops", 32'(n_pops), 1);
        check("t3_done_count", 32'(n_done), 1);
        use_b = 1'b0; tbl_off = 0; nb_exp = 16;

        // 4: err on the fifth transfer, then restart
        slave_clear();
        clear_stats();
        err_at = 4;
        start_req = 1'b1;
        k = 0;
        while (n_bus_err == 0 && k < 100) begin
            mon_cycle();
            k++;
        end
        check("t4_err_seen", 32'(n_bus_err), 1);
        check("t4_acks_before_err", 32'(n_acks), 4);
        mon_cycle();
        check("t4_error_pulse", 32'(m_error), 1);
        check("t4_cyc_stb_after_err", {30'd0, m_cyc, m_stb}, 0);
        check("t4_valid_after_err", 32'(m_valid), 0);
        repeat (8) mon_cycle();
        check("t4_no_done", 32'(n_done), 0);
        check("t4_error_count", 32'(n_error), 1);
        err_at = 1000;
        clear_stats();
        start_req = 1'b1;
        run_burst(200, 4);
        check("t4_restart_pops", 32'(n_pops), 16);
        check("t4_restart_done", 32'(n_done), 1);

        // 5: ignored start mid-burst, then reset while strobing
        slave_clear();
        clear_stats();
        ready_mode = 1;
        start_req = 1'b1;
        k = 0;
        while (n_acks < 3 && k < 100) begin
            mon_cycle();
            k++;
        end
        start_req = 1'b1;
        while (n_acks < 5 && k < 100) begin
            mon_cycle();
            k++;
        end
        check("t5_acks_reached", 32'(n_acks), 5);
        rst_req = 1'b1;
        mon_cycle();
        check("t5_stb_before_rst", 32'(m_stb), 1);
        check("t5_valid_before_rst", 32'(m_valid), 1);
        rst_req = 1'b0;
        mon_cycle();
        check("t5_cyc_stb_after_rst", {30'd0, m_cyc, m_stb}, 0);
        check("t5_busy_after_rst", 32'(m_busy), 0);
        check("t5_valid_after_rst", 32'(m_valid), 0);
        check("t5_adr_after_rst", m_adr, 32'h0000_0000);
        check("t5_done_err_after_rst", {30'd0, m_done, m_error}, 0);
        ready_mode = 0;

        // 6: zero-latency slave, random consumer
        comb_mode = 1'b1;
        ready_mode = 2;
        slave_clear();
        clear_stats();
        start_req = 1'b1;
        run_burst(600, 4);
        check("t6_pops", 32'(n_pops), 16);
        check("t6_done_count", 32'(n_done), 1);
        check("t6_occ_bound", 32'(max_occ <= 8), 1);
        comb_mode = 1'b0;
        ready_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
